// File: rtl/crossing_pkg.sv
// Shared encodings for the crossing scheduler: FSM states and grant classes.
package crossing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CROSS = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic PED = 1'b0;
  localparam logic CYC = 1'b1;

endpackage

// File: rtl/req_sync_edge.sv
// Two-flop synchroniser for an asynchronous button plus a rising-edge detector.
module req_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // A held button yields a single pulse; it must drop before re-triggering.
  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/crossing_scheduler.sv
// Latches pedestrian/cyclist requests, arbitrates them round-robin and sequences
// each granted crossing through a fixed CROSS phase and a road-traffic GAP.
module crossing_scheduler
  import crossing_pkg::*;
#(
  parameter int CROSS_CYCLES = 10,
  parameter int MIN_GAP      = 16,
  parameter int CNT_W        = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ped_req_i,
  input  logic cyc_req_i,
  output logic start_o,
  output logic ped_grant_o,
  output logic cyc_grant_o,
  output logic ped_wait_o,
  output logic cyc_wait_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] CROSS_LOAD = CNT_W'(CROSS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (MIN_GAP > 0) ? CNT_W'(MIN_GAP - 1) : '0;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             ped_wait_q, cyc_wait_q;
  logic             start_q, ped_grant_q, cyc_grant_q, busy_q;

  logic ped_rise, cyc_rise;
  logic launch;
  logic pick_d;
  logic clr_ped, clr_cyc;

  req_sync_edge u_ped_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (ped_req_i),
    .rise_o (ped_rise)
  );

  req_sync_edge u_cyc_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (cyc_req_i),
    .rise_o (cyc_rise)
  );

  assign launch = (state_q == IDLE) && (ped_wait_q || cyc_wait_q);

  // On a tie the class that was not served last wins.
  always_comb begin
    pick_d = PED;
    if (cyc_wait_q && (!ped_wait_q || (last_q == PED))) begin
      pick_d = CYC;
    end
  end

  assign clr_ped = launch && (pick_d == PED);
  assign clr_cyc = launch && (pick_d == CYC);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= CYC;
      ped_wait_q  <= 1'b0;
      cyc_wait_q  <= 1'b0;
      start_q     <= 1'b0;
      ped_grant_q <= 1'b0;
      cyc_grant_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // A fresh edge in the clearing cycle keeps the request pending.
      ped_wait_q <= ped_rise | (ped_wait_q & ~clr_ped);
      cyc_wait_q <= cyc_rise | (cyc_wait_q & ~clr_cyc);
      start_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q     <= CROSS;
            cnt_q       <= CROSS_LOAD;
            start_q     <= 1'b1;
            last_q      <= pick_d;
            ped_grant_q <= (pick_d == PED);
            cyc_grant_q <= (pick_d == CYC);
            busy_q      <= 1'b1;
          end
        end
        CROSS: begin
          if (cnt_q == '0) begin
            ped_grant_q <= 1'b0;
            cyc_grant_q <= 1'b0;
            if (MIN_GAP > 0) begin
              state_q <= GAP;
              cnt_q   <= GAP_LOAD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          ped_grant_q <= 1'b0;
          cyc_grant_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign start_o     = start_q;
  assign ped_grant_o = ped_grant_q;
  assign cyc_grant_o = cyc_grant_q;
  assign ped_wait_o  = ped_wait_q;
  assign cyc_wait_o  = cyc_wait_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler: a timeline model of requests and crossings
// is compared against the DUT every cycle, plus literal start times and reset checks.
module tb_crossing_scheduler;

  localparam int CROSS = 10;
  localparam int GAPC  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ped_req = 1'b0;
  logic cyc_req = 1'b0;
  logic start, ped_grant, cyc_grant, ped_wait, cyc_wait, busy;

  int checks = 0;
  int errors = 0;
  int n = 0;

  // timeline model
  logic [3:0] hp, hc;
  bit  m_ped_wait, m_cyc_wait, m_last;
  int  t_start, next_ok;
  bit  e_start, e_pg, e_cg, e_busy;
  int  dut_starts[$];
  int  m_starts[$];
  int  win_busy, win_pg;

  crossing_scheduler #(
    .CROSS_CYCLES(CROSS),
    .MIN_GAP(GAPC),
    .CNT_W(6)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ped_req_i   (ped_req),
    .cyc_req_i   (cyc_req),
    .start_o     (start),
    .ped_grant_o (ped_grant),
    .cyc_grant_o (cyc_grant),
    .ped_wait_o  (ped_wait),
    .cyc_wait_o  (cyc_wait),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, n, act, exp);
    end
  endtask

  task automatic model_reset();
    hp = '0; hc = '0;
    m_ped_wait = 0; m_cyc_wait = 0; m_last = 1'b1;
    t_start = -1000; next_ok = 0;
  endtask

  task automatic model_step();
    bit pe, ce, cls;
    pe = hp[2] & ~hp[3];
    ce = hc[2] & ~hc[3];
    if (n >= next_ok && (m_ped_wait || m_cyc_wait)) begin
      if (m_ped_wait && m_cyc_wait) cls = ~m_last;
      else cls = m_cyc_wait;
      m_last  = cls;
      t_start = n;
      next_ok = n + CROSS + GAPC + 1;
      m_starts.push_back(n);
      if (cls) m_cyc_wait = 0; else m_ped_wait = 0;
    end
    if (pe) m_ped_wait = 1;
    if (ce) m_cyc_wait = 1;
    e_start = (n == t_start);
    e_busy  = (n >= t_start) && (n < t_start + CROSS + GAPC);
    e_pg    = (n >= t_start) && (n < t_start + CROSS) && !m_last;
    e_cg    = (n >= t_start) && (n < t_start + CROSS) && m_last;
  endtask

  // per-cycle model update and comparison, #1 after each rising edge
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
        n = 0;
      end else begin
        n++;
        hp = {hp[2:0], ped_req};
        hc = {hc[2:0], cyc_req};
        model_step();
        #1;
        check("start", start, e_start);
        check("ped_grant", ped_grant, e_pg);
        check("cyc_grant", cyc_grant, e_cg);
        check("ped_wait", ped_wait, m_ped_wait);
        check("cyc_wait", cyc_wait, m_cyc_wait);
        check("busy", busy, e_busy);
        if (start) dut_starts.push_back(n);
        if (n >= 125 && n <= 165) begin
          win_busy += busy;
          win_pg   += ped_grant;
        end
      end
    end
  end

  task automatic goto(input int k);
    while (n < k) @(negedge clk);
  endtask

  task automatic check_starts(input string nm, input int exp[$]);
    check({nm, "_count"}, dut_starts.size(), exp.size());
    check({nm, "_model_count"}, m_starts.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < dut_starts.size()) check({nm, "_dut"}, dut_starts[i], exp[i]);
      if (i < m_starts.size()) check({nm, "_model"}, m_starts[i], exp[i]);
    end
  endtask

  initial begin
    int exp1[$];
    int exp2[$];
    exp1 = '{63, 90, 133, 173, 200, 243, 270, 297, 333, 444};
    exp2 = '{13, 40};
    win_busy = 0;
    win_pg = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    goto(50);                                   // idle, nothing pending
    check("idle_starts", dut_starts.size(), 0);

    goto(59); ped_req = 1; cyc_req = 1;         // tie after reset: pedestrian first
    goto(62); ped_req = 0; cyc_req = 0;

    goto(129); ped_req = 1;                     // single pedestrian pulse
    goto(130); ped_req = 0;

    goto(169); ped_req = 1; cyc_req = 1;        // tie after pedestrian: cyclist first
    goto(170); ped_req = 0; cyc_req = 0;
    check("win_busy", win_busy, 26);
    check("win_ped_grant", win_pg, 10);

    goto(239); cyc_req = 1;                     // cyclist, re-pressed twice
    goto(240); cyc_req = 0;
    goto(245); cyc_req = 1;
    goto(246); cyc_req = 0;
    goto(267); cyc_req = 1;
    goto(268); cyc_req = 0;
    goto(270);
    check("relatch_on_clear", cyc_wait, 1);

    goto(329); ped_req = 1;                     // held button, then re-press
    goto(429); ped_req = 0;
    goto(440); ped_req = 1;
    goto(441); ped_req = 0;

    goto(445); cyc_req = 1;                     // pending cyclist lost by reset
    goto(446); cyc_req = 0;
    goto(448);
    check_starts("starts_run1", exp1);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_cyc_wait", cyc_wait, 1);

    rst_n = 1'b0;                               // asynchronous reset mid-CROSS
    #1;
    check("rst_start", start, 0);
    check("rst_ped_grant", ped_grant, 0);
    check("rst_cyc_grant", cyc_grant, 0);
    check("rst_ped_wait", ped_wait, 0);
    check("rst_cyc_wait", cyc_wait, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    dut_starts.delete();
    m_starts.delete();
    rst_n = 1'b1;

    goto(9); ped_req = 1; cyc_req = 1;          // tie after reset again: pedestrian first
    goto(10); ped_req = 0; cyc_req = 0;
    goto(80);
    check_starts("starts_run2", exp2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crossing_scheduler.md
Name: crossing_scheduler

Overview:
- Front-end scheduler for the pedestrian/cyclist crossing controller (trafficlight).
- Synchronises and edge-detects two asynchronous request buttons (pedestrian, cyclist) and latches them as pending "wait" requests.
- Arbitrates pending requests round-robin and issues a one-cycle start pulse to the light FSM.
- Enforces a fixed crossing duration and a minimum road-traffic gap before the next crossing.

Parameters:
- CROSS_CYCLES, 10, cycles the granted crossing phase lasts (>=1)
- MIN_GAP, 16, minimum road-green cycles after a crossing before the next start (>=0; 0 skips GAP)
- CNT_W, 6, phase counter width; must hold max(CROSS_CYCLES, MIN_GAP)-1

Ports:
- clock, input, 1, system clock, rising edge
- reset, input, 1, asynchronous, active-low reset
- ped_req, input, 1, raw pedestrian button, asynchronous to clock
- cyc_req, input, 1, raw cyclist button, asynchronous to clock
- start, output, 1, one-cycle pulse to trafficlight.start
- ped_grant, output, 1, high throughout a pedestrian crossing phase
- cyc_grant, output, 1, high throughout a cyclist crossing phase
- ped_wait, output, 1, pedestrian request pending (wait lamp)
- cyc_wait, output, 1, cyclist request pending (wait lamp)
- busy, output, 1, high in CROSS and GAP

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - All outputs 0; synchroniser flops 0.
  - last_grant=CYC, so the pedestrian wins the first tie.
- Input conditioning:
  - Each request passes through a 2-flop synchroniser, then a rising-edge detector (sync2 & ~prev).
  - A button high before edge E0 gives ped_wait/cyc_wait=1 after edge E0+2.
  - A held button counts once; it must return low before it can re-request.
- Wait latches:
  - Set on a detected edge.
  - Cleared for the granted class on the cycle start is asserted.
  - If an edge arrives in the same cycle as the clear, set wins.
  - Requests arriving during CROSS/GAP are latched and served later.
- FSM states: IDLE, CROSS, GAP.
- IDLE:
  - Stays in IDLE while neither wait is set.
  - Any wait set -> CROSS at the next edge.
  - Registered start=1 for exactly that first CROSS cycle.
  - Counter loaded with CROSS_CYCLES-1.
  - Grant selection: only one waiting -> that class. Both waiting -> the class != last_grant. last_grant updated with the choice.
- CROSS:
  - Exactly one of ped_grant/cyc_grant is high for exactly CROSS_CYCLES cycles; counter decrements.
  - At counter==0: go to GAP with counter=MIN_GAP-1, or to IDLE if MIN_GAP=0.
  - start is 0 except on the first cycle.
- GAP:
  - Grants 0, busy=1; counter decrements.
  - At counter==0 -> IDLE.
  - A pending request gets its start on the cycle after IDLE is entered. IDLE therefore lasts exactly one cycle when a request is waiting at GAP exit.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Start spacing: minimum distance between start pulses is CROSS_CYCLES+MIN_GAP+1 cycles.
- Reset mid-operation:
  - Immediate return to reset values.
  - Pending waits are lost and start is deasserted asynchronously.
- Illegal state encodings recover to IDLE.
- Counter width is CNT_W. Comparisons are against zero only, so there is no wrap-around.

Decomposition:
- Shared package crossing_pkg:
  - state encoding localparams IDLE=2'd0, CROSS=2'd1, GAP=2'd2
  - grant-class encoding PED=1'b0, CYC=1'b1
- One sub-module: req_sync_edge. It holds the 2-flop synchroniser, prev flop and rising-pulse output, with the same clock/reset. It is instantiated once per button.

Test Plan:
- Reset then idle 50 cycles, no requests -> start, grants, waits and busy all stay 0.
- Single ped_req pulse high across edge 10 ->
  - ped_wait=1 after edge 12
  - start pulse and ped_grant=1 after edge 13, with ped_wait cleared
  - ped_grant high 10 cycles
  - busy high 26 cycles, then IDLE
- ped_req and cyc_req rise together -> pedestrian served first. Cyclist waits through CROSS+GAP; its start comes 27 cycles after the first start. A second tie afterwards goes to the cyclist first (round-robin).
- cyc_req pressed during cyclist CROSS, and again exactly on the start/clear cycle -> wait re-latched in both cases, and a second cyclist crossing follows after GAP.
- Button held high 100 cycles -> exactly one start; a release and re-press yields a second.
- reset asserted mid-CROSS (counter=5) -> outputs 0 immediately, with no clock needed. After release, the FSM is in IDLE with no pending waits and last_grant=CYC.
